keypad_scanner: RTL and testbench

- Drives and reads a 4x4 matrix keypad (Nexys 4 Pmod), synchronises and debounces it, and emits a one-cycle `newkey` pulse with a 4-bit `keycode`.
- Sits directly upstream of the combination-lock block; its `newkey`/`keycode` outputs connect straight to the lock's inputs.
- Runs on the 5 MHz system clock.

---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_col_driver.sv | 37 +++
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kp_state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_e;

  localparam logic [3:0] COL_RESET = 4'b1110;
  // Also decoded by the combination lock as its clear key.
  localparam logic [3:0] KEY_CLEAR = 4'd11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// rtl/keypad_col_driver.sv - column rotation with end-of-slot and end-of-scan strobes
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       end_slot,
  output logic       end_scan
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  logic [TW-1:0] tick;

  assign end_slot = (tick == TICK_LAST);
  assign end_scan = end_slot && (col_idx == 2'd3);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick    <= '0;
      col     <= COL_RESET;
      col_idx <= 2'd0;
    end else if (end_slot) begin
      tick    <= '0;
      col     <= {col[2:0], col[3]};
      col_idx <= col_idx + 2'd1;
    end else begin
      tick    <= tick + TW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and key-accept FSM
// Optional auto-repeat while a key is held: KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       newkey,
  output logic [3:0] keycode,
  output logic       held
);

  localparam int CW = $clog2(max_int(DEBOUNCE_SCANS, REPEAT_SCANS) + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [3:0]  row_s1, row_s2;
  logic [1:0]  col_idx;
  logic        end_slot, end_scan;
  logic [15:0] hits, hits_now;
  logic [4:0]  nhits;
  logic [3:0]  key;
  scan_res_e   res;
  kp_state_e   state;
  logic [CW-1:0] cnt;
  logic [3:0]  cand;

  keypad_col_driver #(.SCAN_TICKS(SCAN_TICKS)) u_col (
    .clock    (clock),
    .reset    (reset),
    .col      (col),
    .col_idx  (col_idx),
    .end_slot (end_slot),
    .end_scan (end_scan)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // hits bit 4*row+col collects low intersections; the last slot folds in combinationally.
  always_comb begin
    hits_now = hits;
    if (end_slot) begin
      for (int r = 0; r < 4; r++) begin
        if (!row_s2[r]) hits_now[{2'(r), col_idx}] = 1'b1;
      end
    end
    nhits = 5'd0;
    key   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hits_now[i]) begin
        nhits = nhits + 5'd1;
        key   = 4'(i);
      end
    end
    if (nhits == 5'd0)      res = NONE;
    else if (nhits == 5'd1) res = SINGLE;
    else                    res = MULTI;
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_SCANS);
  logic [CW-1:0] rep;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rep <= '0;
    end else if (end_scan) begin
      if (state != HELD) rep <= '0;
      else if (res == SINGLE && key == keycode) rep <= (rep + ONE == REP_LAST) ? '0 : rep + ONE;
      else rep <= '0;
    end
  end

  wire repeat_fire = end_scan && state == HELD && res == SINGLE &&
                     key == keycode && (rep + ONE == REP_LAST);
`else
  wire repeat_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= 4'd0;
      hits    <= '0;
      newkey  <= 1'b0;
      keycode <= 4'd0;
      held    <= 1'b0;
    end else begin
      newkey <= repeat_fire;
      hits   <= end_scan ? '0 : hits_now;
      if (end_scan) begin
        case (state)
          IDLE: begin
            if (res == SINGLE) begin
              cand <= key;
              cnt  <= ONE;
              if (DEBOUNCE_SCANS == 1) begin
                keycode <= key;
                newkey  <= 1'b1;
                held    <= 1'b1;
                state   <= HELD;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (res == SINGLE && key == cand) begin
              if (cnt + ONE == DEB_LAST) begin
                keycode <= cand;
                newkey  <= 1'b1;
                held    <= 1'b1;
                state   <= HELD;
              end else begin
                cnt <= cnt + ONE;
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (res == NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                held  <= 1'b0;
                state <= IDLE;
              end else begin
                cnt   <= ONE;
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (res == NONE) begin
              if (cnt + ONE == DEB_LAST) begin
                held  <= 1'b0;
                state <= IDLE;
              end else begin
                cnt <= cnt + ONE;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scan-aligned directed and random key patterns against a scan-level model
module tb_keypad_scanner;

  localparam int ST  = 4;
  localparam int DEB = 2;
  localparam int REP = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        newkey;
  logic [3:0]  keycode;
  logic        held;
  logic [15:0] keys = '0;

  int compared   = 0;
  int mismatched = 0;

  bit m_held;
  int m_run, m_quiet, m_rep, m_cand, m_code;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
    .clock   (clock),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .newkey  (newkey),
    .keycode (keycode),
    .held    (held)
  );

  // Ideal keypad: a row reads low when a pressed key joins it to a driven-low column.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[4*r +: 4] & ~col);
  end

  function automatic logic [15:0] key_mask(input int k);
    return 16'(1) << k;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_run = 0; m_quiet = 0; m_rep = 0; m_cand = 0; m_code = 0;
  endtask

  // One full scan with a stable key set; returns 1 if a pulse is due at its end.
  task automatic model_scan(input logic [15:0] k, output int pulse);
    int n, idx;
    n = $countones(k);
    idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    pulse = 0;
    if (!m_held) begin
      if (n == 1 && m_run > 0 && idx == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin m_cand = idx; m_run = 1; end
      else m_run = 0;
      if (m_run == DEB) begin
        pulse = 1; m_code = m_cand; m_held = 1; m_run = 0; m_quiet = 0; m_rep = 0;
      end
    end else if (n == 0) begin
      m_rep = 0;
      m_quiet++;
      if (m_quiet == DEB) begin m_held = 0; m_quiet = 0; end
    end else if (m_quiet > 0) begin
      m_quiet = 0; m_rep = 0;
    end else if (n == 1 && idx == m_code) begin
`ifdef KEYPAD_AUTOREPEAT_EN
      m_rep++;
      if (m_rep == REP) begin pulse = 1; m_rep = 0; end
`endif
    end else begin
      m_rep = 0;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    @(posedge clock); #1;
    check({tag, "/col"},     8'(col),     8'h0e);
    check({tag, "/newkey"},  8'(newkey),  8'h00);
    check({tag, "/keycode"}, 8'(keycode), 8'h00);
    check({tag, "/held"},    8'(held),    8'h00);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_scan(input logic [15:0] k, input string tag);
    int exp_pulse;
    int pulses;
    logic last;
    pulses = 0;
    last = 1'b0;
    keys = k;
    for (int c = 0; c < 4*ST; c++) begin
      @(posedge clock); #1;
      if (newkey === 1'b1) pulses++;
      last = newkey;
    end
    model_scan(k, exp_pulse);
    check({tag, "/pulses"},    8'(pulses),  8'(exp_pulse));
    check({tag, "/pulse_pos"}, 8'(last),    8'(exp_pulse));
    check({tag, "/keycode"},   8'(keycode), 8'(m_code));
    check({tag, "/held"},      8'(held),    8'(m_held));
  endtask

  task automatic run_scans(input logic [15:0] k, input int n, input string tag);
    for (int i = 0; i < n; i++) run_scan(k, tag);
  endtask

  initial begin
    logic [15:0] pat;
    int a, b;
    model_reset();
    do_reset("reset0");

    run_scans(key_mask(5), 13, "key5_hold");
    run_scans('0, 4, "key5_release");

    do_reset("reset1");
    run_scans(key_mask(5), 1, "key5_short");
    run_scans('0, 3, "key5_short_rel");

    run_scans(key_mask(2) | key_mask(7), 10, "multi_2_7");
    run_scans(key_mask(2), 3, "key2_after_multi");
    run_scans('0, 3, "key2_release");

    run_scans(key_mask(11), 3, "key11");
    run_scans('0, 1, "bounce_none1");
    run_scans(key_mask(11), 1, "bounce_key11");
    run_scans('0, 3, "bounce_none2");

    run_scans(key_mask(3), 1, "key3_debounce");
    do_reset("reset_mid_debounce");
    run_scans(key_mask(3), 2, "key3_fresh");
    run_scans('0, 3, "key3_release");

    run_scans(key_mask(9), 12, "key9_hold");
    run_scans('0, 3, "key9_release");

    for (int t = 0; t < 40; t++) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 3))
        0:       pat = '0;
        3:       pat = key_mask(a) | key_mask(b);
        default: pat = key_mask(a % 4);
      endcase
      run_scans(pat, $urandom_range(1, 4), "random");
    end
    run_scans('0, 3, "final_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
